// File: rtl/result_serializer_if.sv
// Signals between the hashing control path, the result serializer and the UART transmitter.
// Suffixes are from the serializer's point of view: the serializer uses the slave modport.
interface result_serializer_if;
  logic         start_i;
  logic [255:0] hash_i;
  logic [31:0]  nonce_i;
  logic         tx_active_i;
  logic         tx_done_i;
  logic [7:0]   tx_byte_o;
  logic         tx_dv_o;
  logic         busy_o;
  logic         done_o;

  modport slave (
    input  start_i, hash_i, nonce_i, tx_active_i, tx_done_i,
    output tx_byte_o, tx_dv_o, busy_o, done_o
  );

  modport master (
    output start_i, hash_i, nonce_i, tx_active_i, tx_done_i,
    input  tx_byte_o, tx_dv_o, busy_o, done_o
  );
endinterface

// File: rtl/result_serializer.sv
// Frames {sync, hash[32 bytes LSB first], nonce[4 bytes LSB first], xor checksum} and feeds it
// to the UART transmitter one byte per data-valid/done handshake.
module result_serializer #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic                clk,
  input logic                rst_ni,
  result_serializer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_e;

  localparam logic [5:0] LastIdx = 6'd37;

  state_e       state_q, state_d;
  logic [287:0] shift_q, shift_d;
  logic [5:0]   idx_q, idx_d;
  logic [7:0]   csum_q, csum_d;
  logic [7:0]   tx_byte_q, tx_byte_d;
  logic         tx_dv_q, tx_dv_d;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      idx_q     <= '0;
      csum_q    <= '0;
      tx_byte_q <= '0;
      tx_dv_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      tx_byte_q <= tx_byte_d;
      tx_dv_q   <= tx_dv_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    tx_byte_d = tx_byte_q;
    tx_dv_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          shift_d = {bus.nonce_i, bus.hash_i};
          idx_d   = '0;
          csum_d  = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (!bus.tx_active_i) begin
          tx_dv_d = 1'b1;
          state_d = StWait;
          if (idx_q == 6'd0) begin
            tx_byte_d = SYNC_BYTE;
          end else if (idx_q == LastIdx) begin
            tx_byte_d = csum_q;
          end else begin
            // Payload byte: always the low byte of the shift register.
            tx_byte_d = shift_q[7:0];
            csum_d    = csum_q ^ shift_q[7:0];
            shift_d   = {8'h00, shift_q[287:8]};
          end
        end
      end
      StWait: begin
        if (bus.tx_done_i) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = StSend;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.tx_byte_o = tx_byte_q;
  assign bus.tx_dv_o   = tx_dv_q;
  assign bus.busy_o    = (state_q != StIdle);
  assign bus.done_o    = (state_q == StDone);

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: a frame-level byte queue model plus a UART responder,
// checked every cycle on the falling clock edge.
module tb_result_serializer;

  localparam logic [7:0] Sync = 8'hA5;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         start = 1'b0;
  logic [255:0] hash = '0;
  logic [31:0]  nonce = '0;
  logic         u_done = 1'b0;
  logic         u_active = 1'b0;
  logic         spur_done = 1'b0;
  logic         force_active = 1'b0;

  always #5 clk = ~clk;

  result_serializer_if bus ();

  assign bus.start_i     = start;
  assign bus.hash_i      = hash;
  assign bus.nonce_i     = nonce;
  assign bus.tx_active_i = u_active | force_active;
  assign bus.tx_done_i   = u_done | spur_done;

  result_serializer #(
    .SYNC_BYTE(Sync)
  ) u_dut (
    .clk   (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  int         nvec = 0;
  int         nerr = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got[38];
  logic [7:0] mon_e;
  logic [7:0] held = '0;
  int         frame_issued = 0;
  int         frame_d0 = 0;
  int         done_cnt = 0;
  int         u_cnt = 0;
  int         u_done_cnt = 0;
  int         uart_lat = 10;
  bit         m_busy = 1'b0;
  bit         m_done_exp = 1'b0;
  bit         prev_dv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected frame straight from the byte layout: sync, hash LSB first, nonce LSB first, xor.
  task automatic build_frame(input logic [255:0] h, input logic [31:0] n);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    exp_q.delete();
    exp_q.push_back(Sync);
    for (int k = 0; k < 32; k++) begin
      b = h[8*k +: 8];
      exp_q.push_back(b);
      cs ^= b;
    end
    for (int k = 0; k < 4; k++) begin
      b = n[8*k +: 8];
      exp_q.push_back(b);
      cs ^= b;
    end
    exp_q.push_back(cs);
  endtask

  // Monitor and UART responder.
  always @(negedge clk) begin
    if (rst_ni) begin
      check("busy", 32'(bus.busy_o), 32'(m_busy));
      check("done", 32'(bus.done_o), 32'(m_done_exp));
      if (bus.done_o) done_cnt++;
      if (m_done_exp) begin
        check("bytes_left_at_done", exp_q.size(), 0);
        m_busy = 1'b0;
      end
      m_done_exp = 1'b0;
      if (bus.tx_dv_o) begin
        check("dv_back_to_back", 32'(prev_dv), 0);
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_dv: got byte %0h, want no dv at %0t", bus.tx_byte_o, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("tx_byte", 32'(bus.tx_byte_o), 32'(mon_e));
          if (frame_issued < 38) got[frame_issued] = bus.tx_byte_o;
          frame_issued++;
        end
        held = bus.tx_byte_o;
      end else begin
        check("tx_byte_hold", 32'(bus.tx_byte_o), 32'(held));
      end
      prev_dv = bus.tx_dv_o;
    end
    u_done = 1'b0;
    if (u_cnt > 0) begin
      u_cnt--;
      if (u_cnt == 0) begin
        u_done   = 1'b1;
        u_active = 1'b0;
        u_done_cnt++;
        if (rst_ni && m_busy && frame_issued == 38 && exp_q.size() == 0) m_done_exp = 1'b1;
      end
    end
    if (rst_ni && bus.tx_dv_o) begin
      u_cnt    = uart_lat;
      u_active = 1'b1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic assert_reset();
    rst_ni     = 1'b0;
    exp_q.delete();
    m_busy     = 1'b0;
    m_done_exp = 1'b0;
    frame_issued = 0;
    prev_dv    = 1'b0;
    held       = '0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dv"}, 32'(bus.tx_dv_o), 0);
    check({tag, "_byte"}, 32'(bus.tx_byte_o), 0);
    check({tag, "_busy"}, 32'(bus.busy_o), 0);
    check({tag, "_done"}, 32'(bus.done_o), 0);
  endtask

  task automatic start_frame(input logic [255:0] h, input logic [31:0] n, input bit chk_first);
    tick();
    hash  = h;
    nonce = n;
    start = 1'b1;
    build_frame(h, n);
    frame_issued = 0;
    frame_d0 = done_cnt;
    m_busy = 1'b1;
    tick();
    start = 1'b0;
    if (chk_first) begin
      @(negedge clk);
      check("first_dv_latency", 32'(bus.tx_dv_o), 1);
      check("first_byte_sync", 32'(bus.tx_byte_o), 32'(Sync));
    end
  endtask

  task automatic wait_issued(input int k);
    int t;
    t = 0;
    while (frame_issued < k && t < 3000) begin
      tick();
      t++;
    end
    check("wait_bytes_timeout", 32'(frame_issued >= k), 1);
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (m_busy && t < 3000) begin
      tick();
      t++;
    end
    check("frame_timeout", 32'(m_busy), 0);
    tick();
    check("done_pulses", done_cnt - frame_d0, 1);
    check("frame_len", frame_issued, 38);
  endtask

  logic [255:0] ph;
  int           n0;
  int           c0;

  initial begin
    for (int k = 0; k < 32; k++) ph[8*k +: 8] = 8'(k + 1);

    // Reset
    repeat (3) tick();
    check_outputs_zero("rst_hold");
    rst_ni = 1'b1;
    repeat (3) tick();
    check_outputs_zero("rst_release");

    // Zero frame
    uart_lat = 10;
    start_frame('0, 32'h0, 1'b1);
    wait_end();
    check("zero_sync", 32'(got[0]), 32'hA5);
    check("zero_csum", 32'(got[37]), 32'h00);

    // Pattern frame
    start_frame(ph, 32'hDEADBEEF, 1'b1);
    wait_end();
    check("pat_b1", 32'(got[1]), 32'h01);
    check("pat_b32", 32'(got[32]), 32'h20);
    check("pat_b33", 32'(got[33]), 32'hEF);
    check("pat_b36", 32'(got[36]), 32'hDE);
    check("pat_csum", 32'(got[37]), 32'h02);

    // Backpressure before byte 5
    start_frame(ph, 32'hDEADBEEF, 1'b1);
    wait_issued(5);
    force_active = 1'b1;
    n0 = frame_issued;
    repeat (50) tick();
    check("bp_no_dv", frame_issued, n0);
    force_active = 1'b0;
    @(negedge clk);
    check("bp_release_dv", 32'(bus.tx_dv_o), 1);
    check("bp_release_byte", 32'(bus.tx_byte_o), 32'h05);
    wait_end();
    check("bp_csum", 32'(got[37]), 32'h02);

    // Ignored start / data change and spurious tx_done in SEND
    start_frame(ph, 32'hDEADBEEF, 1'b0);
    wait_issued(13);
    hash  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    nonce = $urandom;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_issued(21);
    force_active = 1'b1;
    repeat (13) tick();
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    repeat (2) tick();
    force_active = 1'b0;
    wait_end();
    check("ign_csum", 32'(got[37]), 32'h02);

    // Random frames, random UART latency, inputs scrambled after capture
    for (int f = 0; f < 4; f++) begin
      uart_lat = $urandom_range(1, 12);
      start_frame({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom}, $urandom, 1'b1);
      hash  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      nonce = $urandom;
      wait_end();
    end

    // Reset mid-frame with a late tx_done
    uart_lat = 10;
    start_frame(ph, 32'hDEADBEEF, 1'b0);
    wait_issued(11);
    c0 = u_done_cnt;
    n0 = done_cnt;
    assert_reset();
    #1;
    check_outputs_zero("rst_async");
    repeat (2) tick();
    rst_ni = 1'b1;
    repeat (20) tick();
    check("late_done_seen", u_done_cnt - c0, 1);
    check("no_done_after_rst", done_cnt - n0, 0);
    start_frame({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom}, $urandom, 1'b1);
    wait_end();
    check("post_rst_sync", 32'(got[0]), 32'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, want $finish before %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/result_serializer.md
# result_serializer

Downstream stage of the hashing core and upstream of the UART transmitter. On a start pulse it snapshots the best hash and its nonce, then frames them and feeds the UART transmitter one byte at a time using the transmitter's data-valid/done handshake. The frame is a sync byte, the payload, and an XOR checksum, which lets the host re-align after dropped bytes. A done pulse lets the control FSM leave its write state.

## Interface
- `SYNC_BYTE`, default 8'hA5: first byte of every frame. Not included in the checksum.
- `clk` in 1: single system clock. All logic is on its rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `start_i` in 1: request to send a frame. Sampled only in IDLE.
- `hash_i` in 256: best hash. Captured on the accepted start.
- `nonce_i` in 32: nonce that produced `hash_i`. Captured on the accepted start.
- `tx_active_i` in 1: UART transmitter busy (o_Tx_Active).
- `tx_done_i` in 1: UART transmitter byte-complete pulse (o_Tx_Done).
- `tx_byte_o` out 8: byte presented to the UART transmitter. Registered.
- `tx_dv_o` out 1: one-cycle data-valid pulse to the UART transmitter. Registered.
- `busy_o` out 1: high whenever state ≠ IDLE.
- `done_o` out 1: one-cycle pulse when the frame is complete.

## Operation
- Frame is 38 bytes: index 0 = `SYNC_BYTE`; indices 1–32 = `hash_i`, LSB byte first; indices 33–36 = `nonce_i`, LSB byte first; index 37 = XOR of bytes 1–36.
- Internal state:
  - 288-bit payload shift register {nonce, hash}, shifted right 8 bits after each payload byte is issued.
  - 6-bit byte index, 0–37.
  - 8-bit checksum accumulator.
- States:
  - IDLE: when `start_i`=1, load the shift register, clear the index and checksum, go to SEND. Otherwise stay in IDLE.
  - SEND: when `tx_active_i`=0, register `tx_byte_o` from the current index, assert `tx_dv_o`, fold payload bytes into the checksum, and go to WAIT. When `tx_active_i`=1, hold in SEND with `tx_dv_o`=0.
  - WAIT: on `tx_done_i`=1, if index = 37 go to DONE; otherwise increment the index and go to SEND.
  - DONE: `done_o`=1 for this cycle only, then go to IDLE.
- Boundary conditions:
  - `start_i` in any state other than IDLE is ignored. Captured data is unaffected.
  - Changes on `hash_i`/`nonce_i` after capture do not affect the frame in flight.
  - `tx_done_i` seen in IDLE, SEND or DONE is ignored.
  - `tx_done_i` and `start_i` in the same cycle: each is handled only by its own state's rule.
  - `tx_byte_o` holds its value between `tx_dv_o` pulses.
  - Reset mid-frame abandons the frame. The UART may finish a byte it already latched; the block ignores the resulting `tx_done_i` because it is then in IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, shift register, index and checksum 0.
- Let `start_i` be sampled high at edge E0 in IDLE:
  - state = SEND after E0;
  - with `tx_active_i`=0, `tx_dv_o`=1 and `tx_byte_o`=`SYNC_BYTE` for the single cycle after E1.
- Per byte: `tx_dv_o` goes high one cycle after entering SEND (when `tx_active_i`=0). It must never be high on two consecutive cycles.
- After the last byte's `tx_done_i` is sampled at edge En:
  - `done_o`=1 and `busy_o`=1 for the cycle after En;
  - `busy_o`=0 one cycle later.
- Minimum frame length is 38 UART byte times plus 3 cycles per byte of handshake overhead, plus 1 cycle.
- A new `start_i` is accepted no earlier than the cycle after `done_o`.

## Test plan
- Reset: assert `rst_ni`=0 mid-cycle -> all outputs 0 immediately (async). Release -> outputs stay 0 with `start_i`=0.
- Zero frame: `hash_i`=0, `nonce_i`=0, model UART answering each `tx_dv_o` with `tx_done_i` 10 cycles later -> bytes A5, 36×00, 00; one `done_o` pulse; exactly 38 `tx_dv_o` pulses.
- Pattern frame: hash byte k = k+1 (so `hash_i[7:0]`=01 … `[255:248]`=20), `nonce_i`=32'hDEADBEEF -> bytes A5, 01…20, EF, BE, AD, DE, checksum 02.
- Backpressure: hold `tx_active_i`=1 for 50 cycles before byte 5 -> no `tx_dv_o` in that window. Byte 5 is issued the cycle after release and the frame content is unchanged.
- Ignored inputs: pulse `start_i` with new `hash_i`/`nonce_i` during byte 12, and inject a spurious `tx_done_i` while in SEND -> frame identical to the pattern frame, still 38 bytes, one `done_o`.
- Reset mid-frame: `rst_ni` low after byte 10's `tx_dv_o`, then a late `tx_done_i` arrives -> block stays IDLE with no `done_o`. Next `start_i` sends a full 38-byte frame starting with A5.
